debug_display_monitor: RTL
==========================

// Module: debug_display_monitor
// PURPOSE
//  Parametrised debug front-end between the core's debug outputs and the board GPIO.
//  - Selects one of NUM_CH debug words, optionally freezes it, and drives a scanned
//    hex seven-segment display.
//  - Debounces NUM_BTN buttons and emits one-cycle press pulses; these feed the core
//    single-step logic.
//  - Replaces the fixed 8-channel, fixed-width debug display path.
// PARAMETERS
//  NUM_CH          8       number of debug channels (need not be a power of 2)
//  DATA_W          32      debug word width; multiple of 4
//  DIGITS          DATA_W/4  number of hex digits scanned
//  NUM_BTN         5       number of debounced buttons
//  DEBOUNCE_CYCLES 20000   stable cycles required before a button level is accepted
//  SCAN_CYCLES     100000  clk cycles each digit stays lit
// PORTS
//  clk        in   1                  system clock, all logic rising-edge
//  aresetn    in   1                  asynchronous active-low reset
//  dbg_in     in   NUM_CH*DATA_W      packed channels; channel k = dbg_in[k*DATA_W +: DATA_W]
//  sel        in   $clog2(NUM_CH)     channel select (from switches)
//  freeze     in   1                  level; high holds the displayed value
//  btn_raw    in   NUM_BTN            raw asynchronous buttons, active-high
//  btn_level  out  NUM_BTN            debounced button level
//  btn_pulse  out  NUM_BTN            one-cycle pulse on debounced rising edge
//  shown      out  DATA_W             value currently being displayed
//  num_an     out  DIGITS             digit enable, active-low, one-hot-low
//  num_csn    out  8                  segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (async, aresetn=0); all outputs registered:
//   - btn_level=0, btn_pulse=0, shown=0
//   - num_an = all 1s (all digits dark), num_csn = 8'hFF
//   - all counters, digit index and sync flops = 0; snapshot = 0
//  Channel path:
//   - live = (sel < NUM_CH) ? channel[sel] : 0
//   - shown <= freeze ? snap : live; one-cycle latency from dbg_in/sel to shown
//   - snap <= live on the cycle freeze is sampled 0->1 (edge register reset 0)
//   - snap holds while freeze=1; sel/dbg_in changes are ignored until freeze=0
//   - freeze 1->0: shown tracks live again on the next cycle
//  Debounce (per button i, independent):
//   - btn_raw passes through a 2-flop synchroniser -> s[i]
//   - cnt[i] clears whenever s[i]==btn_level[i]; otherwise cnt[i] increments
//   - when cnt[i]==DEBOUNCE_CYCLES-1 while mismatched: btn_level[i]<=s[i], cnt[i]<=0
//   - glitch shorter than DEBOUNCE_CYCLES: level unchanged, no pulse
//   - btn_pulse[i]=1 exactly in the cycle after btn_level[i] rises 0->1; 0 on falls
//   - holding a button produces one pulse only
//   - total latency raw edge -> level = 2 + DEBOUNCE_CYCLES cycles
//  Scan:
//   - scan_cnt counts 0..SCAN_CYCLES-1, then wraps to 0
//   - digit index d advances on each wrap; DIGITS-1 wraps to 0
//   - num_an <= ~(1<<d), registered
//   - nibble = shown[4*d +: 4]; digit 0 is the least-significant nibble
//   - num_csn <= ~{1'b0, seg7(nibble)}: dp always off; standard hex font
//     0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//   - num_an and num_csn update in the same cycle, so there is no ghosting
//  Reset mid-operation:
//   - every counter and output returns to its reset value immediately
//   - a button held through reset release reads level 0, then after the debounce
//     latency rises and pulses once
// TESTING  (bench uses DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, NUM_CH=5, DATA_W=32)
//  1 reset: aresetn=0 while any stimulus -> num_an=FF, num_csn=FF, shown=0, btn_*=0
//  2 select: ch3=32'h1234_ABCD, sel=3 -> shown=1234ABCD next cycle;
//    sel=6 -> shown=0
//  3 freeze: sel=1 (ch1=32'hDEADBEEF), raise freeze, change ch1 and sel=2 -> shown stays
//    DEADBEEF; drop freeze -> shown=ch2
//  4 debounce: btn_raw[0] high 3 cycles -> no pulse;
//    high 10 cycles -> btn_level[0] rises 6 cycles after raw edge, btn_pulse[0] is a
//    single 1-cycle pulse; hold high 50 cycles -> still one pulse
//  5 scan: shown=32'h0000_00A5 -> digit0 lit 3 cycles with num_csn=~8'h6D,
//    digit1 with ~8'h77, digits2..7 with ~8'h3F; digit7 wraps to digit0
//  6 async reset during a held button and mid-scan -> outputs reset in the same cycle;
//    after release, one fresh pulse

Source files
------------

// File: rtl/debug_display_monitor_if.sv
// Interface bundling the debug display monitor's data, button and display signals.
// The master side drives the channels, select, freeze and raw buttons; the slave is the monitor.
interface debug_display_monitor_if #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 32,
  parameter int DIGITS  = DATA_W / 4,
  parameter int NUM_BTN = 5
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] dbg_in;
  logic [SEL_W-1:0]         sel;
  logic                     freeze;
  logic [NUM_BTN-1:0]       btn_raw;
  logic [NUM_BTN-1:0]       btn_level;
  logic [NUM_BTN-1:0]       btn_pulse;
  logic [DATA_W-1:0]        shown;
  logic [DIGITS-1:0]        num_an;
  logic [7:0]               num_csn;

  modport master (
    output dbg_in, sel, freeze, btn_raw,
    input  btn_level, btn_pulse, shown, num_an, num_csn
  );

  modport slave (
    input  dbg_in, sel, freeze, btn_raw,
    output btn_level, btn_pulse, shown, num_an, num_csn
  );
endinterface

// File: rtl/debug_display_monitor.sv
// Debug front-end: channel select with freeze, scanned hex seven-segment display,
// and per-button synchroniser/debouncer producing debounced levels and press pulses.
module debug_display_monitor #(
  parameter int NUM_CH          = 8,
  parameter int DATA_W          = 32,
  parameter int DIGITS          = DATA_W / 4,
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_CYCLES     = 100000
) (
  input logic                   clk,
  input logic                   aresetn,
  debug_display_monitor_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- channel path
  logic [DATA_W-1:0] live;
  logic              freeze_q;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [DATA_W-1:0] shown_q, shown_d;

  // Out-of-range selects match no channel and therefore show zero.
  always_comb begin
    live = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        live = bus.dbg_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // The snapshot is taken from the same live value that would otherwise have been shown,
  // so the first frozen cycle already displays the captured word.
  always_comb begin
    snap_d  = snap_q;
    shown_d = live;
    if (bus.freeze && !freeze_q) begin
      snap_d = live;
    end
    if (bus.freeze) begin
      shown_d = snap_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      freeze_q <= 1'b0;
      snap_q   <= '0;
      shown_q  <= '0;
    end else begin
      freeze_q <= bus.freeze;
      snap_q   <= snap_d;
      shown_q  <= shown_d;
    end
  end

  assign bus.shown = shown_q;

  // ---------------------------------------------------------------- debounce
  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] pulse_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [1:0]      sync_q;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            level_q, level_d;
      logic            level_dly_q;
      logic            pulse_q;

      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          sync_q      <= 2'b00;
          cnt_q       <= '0;
          level_q     <= 1'b0;
          level_dly_q <= 1'b0;
          pulse_q     <= 1'b0;
        end else begin
          sync_q      <= {sync_q[0], bus.btn_raw[gi]};
          cnt_q       <= cnt_d;
          level_q     <= level_d;
          level_dly_q <= level_q;
          pulse_q     <= level_q & ~level_dly_q;
        end
      end

      assign level_vec[gi] = level_q;
      assign pulse_vec[gi] = pulse_q;
    end
  endgenerate

  assign bus.btn_level = level_vec;
  assign bus.btn_pulse = pulse_vec;

  // ---------------------------------------------------------------- display scan
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [DIGITS-1:0] num_an_q, num_an_d;
  logic [7:0]        num_csn_q, num_csn_d;
  logic [3:0]        nibble;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SC_W'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      digit_d    = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  // Anode and segment patterns derive from the same digit index and register together.
  always_comb begin
    nibble   = 4'h0;
    num_an_d = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_q == DIG_W'(d)) begin
        nibble      = shown_q[d*4 +: 4];
        num_an_d[d] = 1'b0;
      end
    end
    num_csn_d = ~{1'b0, seg7(nibble)};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
      num_an_q   <= '1;
      num_csn_q  <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      num_an_q   <= num_an_d;
      num_csn_q  <= num_csn_d;
    end
  end

  assign bus.num_an  = num_an_q;
  assign bus.num_csn = num_csn_q;
endmodule
